// File: rtl/pokey_enable_gen.sv
// rtl/pokey_enable_gen.sv - phase-locked 1.79 MHz / 64 kHz / 15 kHz clock-enable strobes
module pokey_enable_gen #(
    parameter int CLK_DIV = 16,
    parameter int DIV64   = 28,
    parameter int DIV15   = 114
) (
    input  logic clk,
    input  logic reset_n,
    input  logic init,
    output logic enable_179,
    output logic enable_64,
    output logic enable_15
);

    localparam int C64_W = $clog2(DIV64);
    localparam int C15_W = $clog2(DIV15);
    localparam logic [C64_W-1:0] C64_LAST = C64_W'(DIV64 - 1);
    localparam logic [C15_W-1:0] C15_LAST = C15_W'(DIV15 - 1);

    logic             tick;
    logic [C64_W-1:0] c64;
    logic [C15_W-1:0] c15;
    logic             clear;

    assign clear = !reset_n || init;

    // A divide-by-one prescaler has no state: every clk is a machine cycle.
    generate
        if (CLK_DIV == 1) begin : g_no_prescale
            assign tick = 1'b1;
        end else begin : g_prescale
            localparam int P_W = $clog2(CLK_DIV);
            localparam logic [P_W-1:0] P_LAST = P_W'(CLK_DIV - 1);
            logic [P_W-1:0] p;

            assign tick = (p == P_LAST);

            always_ff @(posedge clk) begin
                if (clear) begin
                    p <= '0;
                end else if (tick) begin
                    p <= '0;
                end else begin
                    p <= p + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            c64 <= '0;
            c15 <= '0;
        end else if (tick) begin
            c64 <= (c64 == C64_LAST) ? '0 : c64 + 1'b1;
            c15 <= (c15 == C15_LAST) ? '0 : c15 + 1'b1;
        end
    end

    // Base strobes are qualified by tick so they always land on a machine cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            enable_179 <= 1'b0;
            enable_64  <= 1'b0;
            enable_15  <= 1'b0;
        end else begin
            enable_179 <= tick;
            enable_64  <= tick && (c64 == C64_LAST);
            enable_15  <= tick && (c15 == C15_LAST);
        end
    end

endmodule

// File: tb/tb_pokey_enable_gen.sv
// tb/tb_pokey_enable_gen.sv - self-checking bench for pokey_enable_gen
module tb_pokey_enable_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic init = 1'b0;
    logic a179, a64, a15;
    logic b179, b64, b15;

    always #5 clk = ~clk;

    pokey_enable_gen #(.CLK_DIV(4), .DIV64(28), .DIV15(114)) dut_a (
        .clk(clk), .reset_n(reset_n), .init(init),
        .enable_179(a179), .enable_64(a64), .enable_15(a15)
    );

    pokey_enable_gen #(.CLK_DIV(1), .DIV64(2), .DIV15(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .init(init),
        .enable_179(b179), .enable_64(b64), .enable_15(b15)
    );

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    // n = active edges since the last clearing edge; a strobe with period P
    // is expected whenever n is a positive multiple of P.
    int n = 0;
    always @(posedge clk) begin
        if (!reset_n || init) n <= 0;
        else n <= n + 1;
    end

    function automatic logic due(int cnt, int period);
        return (cnt > 0) && (cnt % period == 0);
    endfunction

    task automatic check(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b (n=%0d t=%0t)", name, act, exp, n, $time);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check("model_a179", a179, due(n, 4));
            check("model_a64",  a64,  due(n, 112));
            check("model_a15",  a15,  due(n, 456));
            check("model_b179", b179, due(n, 1));
            check("model_b64",  b64,  due(n, 2));
            check("model_b15",  b15,  due(n, 3));
            check("align_a", (a64 || a15) ? a179 : 1'b1, 1'b1);
        end
    end

    // Called right after the clearing input is released at a negedge.
    task automatic release_seq(string tag);
        for (int i = 1; i <= 112; i++) begin
            @(negedge clk);
            if (i <= 4) check($sformatf("%s_179_c%0d", tag, i), a179, i == 4);
            if (i >= 111) check($sformatf("%s_64_c%0d", tag, i), a64, i == 112);
        end
    endtask

    typedef struct {
        int   cycle;
        logic e179;
        logic e64;
        logic e15;
    } vec_t;

    vec_t vecs[$];
    int   cnt_a179, cnt_a64, cnt_a15, cnt_b179, cnt_b64, cnt_b15;
    int   vi;

    initial begin
        vecs = '{
            '{1, 0, 0, 0}, '{3, 0, 0, 0}, '{4, 1, 0, 0}, '{5, 0, 0, 0},
            '{8, 1, 0, 0}, '{111, 0, 0, 0}, '{112, 1, 1, 0}, '{113, 0, 0, 0},
            '{224, 1, 1, 0}, '{455, 0, 0, 0}, '{456, 1, 0, 1}, '{912, 1, 0, 1},
            '{6384, 1, 1, 1}
        };

        repeat (3) @(negedge clk);
        model_on = 1'b1;
        check("reset_a179", a179, 1'b0);
        check("reset_a64",  a64,  1'b0);
        check("reset_a15",  a15,  1'b0);
        check("reset_b179", b179, 1'b0);

        // Long run: table checkpoints plus pulse counts.
        reset_n = 1'b1;
        cnt_a179 = 0; cnt_a64 = 0; cnt_a15 = 0;
        cnt_b179 = 0; cnt_b64 = 0; cnt_b15 = 0;
        vi = 0;
        for (int cyc = 1; cyc <= 45600; cyc++) begin
            @(negedge clk);
            cnt_a179 += int'(a179); cnt_a64 += int'(a64); cnt_a15 += int'(a15);
            cnt_b179 += int'(b179); cnt_b64 += int'(b64); cnt_b15 += int'(b15);
            if (vi < vecs.size() && vecs[vi].cycle == cyc) begin
                check($sformatf("vec_179_c%0d", cyc), a179, vecs[vi].e179);
                check($sformatf("vec_64_c%0d", cyc),  a64,  vecs[vi].e64);
                check($sformatf("vec_15_c%0d", cyc),  a15,  vecs[vi].e15);
                vi++;
            end
        end
        check_int("count_a179", cnt_a179, 11400);
        check_int("count_a64",  cnt_a64,  407);
        check_int("count_a15",  cnt_a15,  100);
        check_int("count_b179", cnt_b179, 45600);
        check_int("count_b64",  cnt_b64,  22800);
        check_int("count_b15",  cnt_b15,  15200);
        check_int("vec_coverage", vi, vecs.size());

        // init held for ten edges mid-period.
        repeat (50) @(negedge clk);
        init = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("init_hold_a179", a179, 1'b0);
            check("init_hold_b179", b179, 1'b0);
        end
        init = 1'b0;
        release_seq("init_rel");

        // One-edge reset while a machine-cycle tick is pending.
        for (int i = 0; i < 8 && (n % 4) != 3; i++) @(negedge clk);
        check_int("pending_phase", n % 4, 3);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_a179", a179, 1'b0);
        check("rst_mid_b179", b179, 1'b0);
        reset_n = 1'b1;
        release_seq("rst_rel");

        // Reset and init together, then reset released while init is held.
        repeat (37) @(negedge clk);
        reset_n = 1'b0;
        init = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("both_hold_a179", a179, 1'b0);
            check("both_hold_b179", b179, 1'b0);
        end
        init = 1'b0;
        release_seq("both_rel");

        // Random run lengths interleaved with reset/init bursts.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(1, 600)) @(negedge clk);
            if ($urandom_range(0, 1) == 0) reset_n = 1'b0;
            else init = 1'b1;
            if ($urandom_range(0, 3) == 0) init = 1'b1;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            reset_n = 1'b1;
            init = 1'b0;
        end
        repeat (500) @(negedge clk);

        model_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
